dlfloat_mac_seq: RTL and testbench

DLFLOAT_MAC_SEQ -- requirements
Module: dlfloat_mac_seq

---
 rtl/dlfloat_pkg.sv | 17 +
 rtl/mac_lat_timer.sv | 35 +++
 rtl/dlfloat_mac_seq.sv | 139 +++++++++++++
 tb/tb_dlfloat_mac_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants and the MAC sequencer state encoding.
// Imported by the sequencer top and its helper blocks.
package dlfloat_pkg;

  localparam int DLF_W = 16;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD
  } state_e;

endpackage

// File: rtl/mac_lat_timer.sv
// Loadable down-counter with a done flag; measures the MAC pipeline
// drain time after the final operand pair has been issued.
module mac_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dlfloat_mac_seq.sv
// Sequences one DLFloat dot-product job through an external MAC
// datapath and holds the accumulated result until it is consumed.
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DLF_W-1:0] in_a,
  input  logic [DLF_W-1:0] in_b,
  output logic [DLF_W-1:0] mac_a,
  output logic [DLF_W-1:0] mac_b,
  output logic             mac_clr,
  input  logic [DLF_W-1:0] mac_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DLF_W-1:0] res_data
);

  localparam int TW =
    (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic [DLF_W-1:0] a_q;
  logic [DLF_W-1:0] a_d;
  logic [DLF_W-1:0] b_q;
  logic [DLF_W-1:0] b_d;
  logic [DLF_W-1:0] res_q;
  logic [DLF_W-1:0] res_d;
  logic             clr_q;
  logic             clr_d;
  logic             tmr_load;
  logic             tmr_done;

  assign cnt_inc = cnt_q + LEN_W'(1);

  mac_lat_timer #(
    .W (TW)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .val_i  (TW'(MAC_LAT)),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    a_d       = DLF_ZERO;
    b_d       = DLF_ZERO;
    clr_d     = 1'b0;
    res_d     = res_q;
    tmr_load  = 1'b0;
    busy      = 1'b1;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d   = (cfg_len == '0) ? LEN_W'(1)
                                    : cfg_len;
          cnt_d   = '0;
          clr_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            tmr_load = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // last operand has fully propagated to mac_c
        if (tmr_done) begin
          res_d   = mac_c;
          state_d = HOLD;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      a_q     <= DLF_ZERO;
      b_q     <= DLF_ZERO;
      clr_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
      res_q   <= res_d;
    end
  end

  assign mac_a    = a_q;
  assign mac_b    = b_q;
  assign mac_clr  = clr_q;
  assign res_data = res_q;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Randomized scoreboard bench for dlfloat_mac_seq against a
// cycle-level job model driven by the bench's own mac_c pattern.
module tb_dlfloat_mac_seq;

  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_clr;
  logic [15:0]      mac_c;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;

  int cyc;
  int n_cmp;
  int n_bad;

  dlfloat_mac_seq #(
    .MAC_LAT (MAC_LAT),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .mac_c     (mac_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] macfn(input int c);
    logic [31:0] v;
    v = (c * 40503) ^ (c >> 3) ^ 32'h5A5A;
    return v[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  assign mac_c = macfn(cyc);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, exp);
    end
  endtask

  // job-level reference model
  bit          seen_rst;
  bit          act;
  int          rem;
  int          s_cyc;
  int          t_last;
  int          acc_cyc;
  logic [15:0] la;
  logic [15:0] lb;
  logic [15:0] res_e;
  logic [15:0] res_q[$];

  initial begin
    seen_rst = 0;
    act      = 0;
    rem      = 0;
    s_cyc    = -9;
    t_last   = -1;
    acc_cyc  = -9;
    la       = '0;
    lb       = '0;
    res_e    = '0;
  end

  always @(negedge clk) begin
    int  k;
    bit  rv_e;
    k    = cyc;
    rv_e = act && t_last >= 0 &&
           k >= t_last + MAC_LAT + 2;
    if (seen_rst) begin
      chk("busy", busy, act);
      chk("in_ready", in_ready, act && rem > 0);
      chk("res_valid", res_valid, rv_e);
      chk("mac_clr", mac_clr, k == s_cyc + 1);
      chk("mac_a", mac_a,
          (k == acc_cyc + 1) ? la : 16'h0000);
      chk("mac_b", mac_b,
          (k == acc_cyc + 1) ? lb : 16'h0000);
      chk("res_data", res_data, res_e);
    end
    if (!rst_n) begin
      act      = 0;
      rem      = 0;
      s_cyc    = -9;
      t_last   = -1;
      acc_cyc  = -9;
      res_e    = '0;
      res_q.delete();
      seen_rst = 1;
    end else if (seen_rst) begin
      if (act && t_last >= 0 &&
          k == t_last + MAC_LAT + 1)
        res_e = macfn(k);
      if (!act) begin
        if (start) begin
          act    = 1;
          rem    = (cfg_len == 0) ? 1 : int'(cfg_len);
          s_cyc  = k;
          t_last = -1;
        end
      end else if (rem > 0) begin
        if (in_valid) begin
          la      = in_a;
          lb      = in_b;
          acc_cyc = k;
          rem--;
          if (rem == 0) begin
            t_last = k;
            res_q.push_back(macfn(k + MAC_LAT + 1));
          end
        end
      end else if (rv_e && res_ready) begin
        act = 0;
      end
    end
  end

  // result monitor: pops on every consumed result
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result cyc=%0d actual=%h required=none",
                 cyc, res_data);
      end else begin
        chk("result", res_data, res_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_job(input int cfg, input int mode,
                        input int hold, input bit one);
    int n;
    int got;
    int c;
    bit acc;
    n       = (cfg == 0) ? 1 : cfg;
    start   = 1'b1;
    cfg_len = LEN_W'(cfg);
    tick();
    start   = 1'b0;
    cfg_len = LEN_W'($urandom);
    got     = 0;
    c       = 0;
    while (got < n && c < 2000) begin
      unique case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_a = one ? 16'h3E00 : 16'($urandom);
      in_b = one ? 16'h3E00 : 16'($urandom);
      acc  = in_valid && in_ready;
      tick();
      if (acc) got++;
      c++;
    end
    if (got < n) chk("load_timeout", got, n);
    in_valid = 1'b1;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    c        = 0;
    while (!res_valid && c < 40) begin
      start = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    if (!res_valid) chk("res_timeout", res_valid, 1);
    for (int j = 0; j < hold; j++) begin
      start     = 1'($urandom_range(0, 1));
      res_ready = 1'b0;
      tick();
    end
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    int got;
    n_cmp     = 0;
    n_bad     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    do_job(1, 0, 0, 1'b1);
    do_job(0, 0, 2, 1'b0);
    do_job(4, 1, 0, 1'b0);
    do_job(3, 2, 10, 1'b0);

    start   = 1'b1;
    cfg_len = 8'd4;
    tick();
    start   = 1'b0;
    got     = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      if (in_ready) got++;
      tick();
    end
    rst_n    = 1'b0;
    in_valid = 1'b1;
    start    = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    do_job(2, 0, 1, 1'b0);

    do_job(255, 0, 0, 1'b0);
    for (int j = 0; j < 25; j++) begin
      do_job($urandom_range(0, 12), 2,
             $urandom_range(0, 3), 1'b0);
    end
    tick();
    chk("queue_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=done",
             cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
